bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
//   Sits between the 8-bit accumulator/adder datapath and the HEX display decoders.
//   Converts an unsigned binary word into DIGITS packed BCD digits.
//   Replaces divide/modulo display logic with a small iterative datapath.
// PARAMETERS
//   WIDTH   8   bit width of binary input
//   DIGITS  3   number of BCD output digits (4 bits each)
// PORTS
//   clock     in   1           system clock, all state updates on posedge
//   resetn    in   1           asynchronous, active-low reset
//   start     in   1           request conversion of bin (sampled on posedge)
//   bin       in   WIDTH       unsigned binary value, captured when start is accepted
//   busy      out  1           high while conversion in progress
//   done      out  1           one-cycle pulse, bcd/overflow just updated
//   bcd       out  4*DIGITS    result; digit k at bits [4k+3:4k], k=0 is units
//   overflow  out  1           last result did not fit in DIGITS digits
//   seg       out  7*DIGITS    (BCD_SEG7_EN only) active-low 7-seg per digit, gfedcba
// BEHAVIOUR
//   Interface: one clock (clock); reset is asynchronous and active-low (resetn).
//   Reset: state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift/work regs=0.
//   FSM states:
//     IDLE   start=1 -> capture bin into shift reg, clear work reg and ovf flag,
//            count=WIDTH, go to SHIFT.
//     SHIFT  each cycle: every work digit >=5 gets +3, then {ovf_bit,work,shift} <<= 1;
//            a 1 leaving the top digit's MSB sets sticky ovf flag; count--.
//            On the cycle count reaches 1 -> go to DONE. bcd/overflow load on the same edge.
//     DONE   one cycle, then IDLE. start here is accepted as in IDLE (back-to-back).
//   busy = (state==SHIFT), registered; done = (state==DONE).
//   Latency: start sampled at edge 0 -> busy high for WIDTH cycles -> done high in cycle
//     after edge WIDTH (WIDTH+1 cycles start-to-done); throughput one conversion per WIDTH+1.
//   start while busy: ignored, bin not re-captured, no effect on current result.
//   bcd/overflow hold last result until next DONE. They are not cleared by start.
//   Overflow: if the ovf flag is set at completion, overflow=1 and bcd saturates to
//     all digits = 9. Otherwise overflow=0 and bcd is exact.
//   Digit add-3 uses 4-bit arithmetic; each corrected digit stays <=12, so no carry between digits.
//   resetn low mid-conversion: abort immediately, all outputs to reset values, no done pulse.
// CONFIGURATION
//   BCD_SEG7_EN defined: port seg present; each digit registered-decoded from bcd
//     (0-9 standard glyphs, 0=7'b1000000). seg updates the cycle after bcd, so it is
//     valid one cycle after done. seg resets to all 7'b1000000.
//   BCD_SEG7_EN undefined: no seg port, no decoder logic. All other behaviour identical.
// STRUCTURE
//   Package bin2bcd_pkg: state enum {IDLE,SHIFT,DONE}; SEG7 glyph constants 0-9 and
//     SEG7_BLANK; localparam for add-3 threshold (4'd5).
//   Sub-module bcd_seg7_digit: one 4-bit -> 7-bit decoder, generate-instantiated
//     DIGITS times, only under BCD_SEG7_EN. Non-BCD input (10-15) -> SEG7_BLANK.
//   Count register width = $clog2(WIDTH+1).
// TESTING
//   T1: bin=8'd255, start 1 cycle -> busy 8 cycles, done at cycle 9, bcd=12'h255, overflow=0.
//   T2: bin=0 then bin=99 back-to-back (start during DONE) -> bcd=12'h000, then 12'h099,
//     two done pulses 9 cycles apart.
//   T3: start bin=128, re-pulse start bin=7 while busy -> single done, bcd=12'h128.
//   T4: DIGITS=2, bin=200 -> bcd=8'h99, overflow=1; then bin=42 -> bcd=8'h42, overflow=0.
//   T5: resetn low at SHIFT cycle 4 -> busy/done/bcd/overflow 0 async, no done after release.
//   T6 (BCD_SEG7_EN): bin=8'd37 -> cycle after done seg={7'b1000000,7'b0110000,7'b1111000}.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Glyphs are active-low, bit order gfedcba.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  localparam logic [6:0] SEG7_0     = 7'b1000000;
  localparam logic [6:0] SEG7_1     = 7'b1111001;
  localparam logic [6:0] SEG7_2     = 7'b0100100;
  localparam logic [6:0] SEG7_3     = 7'b0110000;
  localparam logic [6:0] SEG7_4     = 7'b0011001;
  localparam logic [6:0] SEG7_5     = 7'b0010010;
  localparam logic [6:0] SEG7_6     = 7'b0000010;
  localparam logic [6:0] SEG7_7     = 7'b1111000;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0010000;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle of bin2bcd_seq. The seg field exists only when
// BCD_SEG7_EN is defined.
interface bin2bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
`ifdef BCD_SEG7_EN
  logic [7*DIGITS-1:0]   seg;

  modport master (output start, bin, input busy, done, bcd, overflow, seg);
  modport slave  (input start, bin, output busy, done, bcd, overflow, seg);
`else
  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
`endif
endinterface

// File: rtl/bcd_seg7_digit.sv
// One BCD digit to active-low 7-segment glyph; non-BCD codes blank the digit.
// Only compiled when BCD_SEG7_EN is defined.
`ifdef BCD_SEG7_EN
module bcd_seg7_digit
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG7_BLANK;
    case (digit)
      4'd0:    seg_c = SEG7_0;
      4'd1:    seg_c = SEG7_1;
      4'd2:    seg_c = SEG7_2;
      4'd3:    seg_c = SEG7_3;
      4'd4:    seg_c = SEG7_4;
      4'd5:    seg_c = SEG7_5;
      4'd6:    seg_c = SEG7_6;
      4'd7:    seg_c = SEG7_7;
      4'd8:    seg_c = SEG7_8;
      4'd9:    seg_c = SEG7_9;
      default: seg_c = SEG7_BLANK;
    endcase
  end

endmodule
`endif

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock.
// Optional registered 7-segment outputs under BCD_SEG7_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic          clock,
  input logic          resetn,
  bin2bcd_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  state_t             state_q, state_nxt;
  logic [WIDTH-1:0]   shift_q, shift_nxt;
  logic [BCD_W-1:0]   work_q, work_nxt;
  logic [BCD_W-1:0]   adj;
  logic               ovf_q, ovf_nxt, ovf_bit;
  logic [CNT_W-1:0]   count_q, count_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic [BCD_W-1:0]   bcd_q, bcd_nxt;
  logic               overflow_q, overflow_nxt;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  // Next state, datapath update and output loads
  always_comb begin
    state_nxt    = state_q;
    shift_nxt    = shift_q;
    work_nxt     = work_q;
    ovf_nxt      = ovf_q;
    ovf_bit      = 1'b0;
    count_nxt    = count_q;
    bcd_nxt      = bcd_q;
    overflow_nxt = overflow_q;
    adj          = work_q;

    // Digits stay <= 12 after correction, so no inter-digit carry is needed
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= ADD3_THRESHOLD)
        adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          shift_nxt = bus.bin;
          work_nxt  = '0;
          ovf_nxt   = 1'b0;
          count_nxt = CNT_W'(WIDTH);
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        {ovf_bit, work_nxt, shift_nxt} = {adj, shift_q, 1'b0};
        ovf_nxt   = ovf_q | ovf_bit;
        count_nxt = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_nxt    = DONE;
          overflow_nxt = ovf_nxt;
          bcd_nxt      = ovf_nxt ? {DIGITS{4'd9}} : work_nxt;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == SHIFT);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_q    <= '0;
      work_q     <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_nxt;
      work_q     <= work_nxt;
      ovf_q      <= ovf_nxt;
      count_q    <= count_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      bcd_q      <= bcd_nxt;
      overflow_q <= overflow_nxt;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;

`ifdef BCD_SEG7_EN
  logic [7*DIGITS-1:0] seg_c;
  logic [7*DIGITS-1:0] seg_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_seg7_digit u_digit (
      .digit (bcd_q[4*g +: 4]),
      .seg_c (seg_c[7*g +: 7])
    );
  end

  // Glyphs lag bcd by one cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) seg_q <= {DIGITS{SEG7_0}};
    else         seg_q <= seg_c;
  end

  assign bus.seg = seg_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq: a 3-digit and a 2-digit
// instance run the same stimulus against a decimal-arithmetic reference.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  logic clock;
  logic resetn;

  bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus_a ();
  bin2bcd_seq_if #(.WIDTH(8), .DIGITS(2)) bus_b ();

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_a.slave)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] prev_a = '0;
  logic [7:0]  prev_b = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decimal reference: exact digits, or all nines when the value needs more digits
  function automatic logic [11:0] ref_bcd(input int v, input int digits);
    int lim = 1;
    int x = v;
    logic [11:0] r = '0;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = (v >= lim) ? 4'd9 : 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int digits);
    int lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return (v >= lim);
  endfunction

`ifdef BCD_SEG7_EN
  function automatic logic [20:0] ref_seg(input logic [11:0] b);
    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [20:0] r = '0;
    logic [3:0]  d;
    for (int i = 0; i < 3; i++) begin
      d = b[4*i +: 4];
      r[7*i +: 7] = (d <= 4'd9) ? glyph[d] : 7'h7f;
    end
    return r;
  endfunction
`endif

  task automatic drive(input logic s, input int v);
    bus_a.start = s;
    bus_b.start = s;
    bus_a.bin   = 8'(v);
    bus_b.bin   = 8'(v);
  endtask

  // Called at a negedge; returns at the negedge where done is observed
  task automatic convert(input int v, input bit poke);
    int lat = 0;
    int busy_cnt = 0;
    logic [11:0] exp_a;
    logic [7:0]  exp_b;
    drive(1'b1, v);
    @(negedge clock);
    lat = 1;
    drive(1'b0, v);
    check("hold_bcd_a", 32'(bus_a.bcd), 32'(prev_a));
    check("hold_bcd_b", 32'(bus_b.bcd), 32'(prev_b));
`ifdef BCD_SEG7_EN
    check("seg_a", 32'(bus_a.seg), 32'(ref_seg(prev_a)));
`endif
    while (!bus_a.done && lat < 40) begin
      if (bus_a.busy) busy_cnt++;
      if (poke && lat == 3) drive(1'b1, 7);
      else if (poke && lat == 4) drive(1'b0, 7);
      @(negedge clock);
      lat++;
    end
    check("latency", 32'(lat), 32'd9);
    check("busy_cycles", 32'(busy_cnt), 32'd8);
    check("done_b", 32'(bus_b.done), 32'd1);
    check("busy_at_done", 32'(bus_a.busy), 32'd0);
    exp_a = ref_bcd(v, 3);
    exp_b = 8'(ref_bcd(v, 2));
    check("bcd_a", 32'(bus_a.bcd), 32'(exp_a));
    check("ovf_a", 32'(bus_a.overflow), 32'(ref_ovf(v, 3)));
    check("bcd_b", 32'(bus_b.bcd), 32'(exp_b));
    check("ovf_b", 32'(bus_b.overflow), 32'(ref_ovf(v, 2)));
    prev_a = exp_a;
    prev_b = exp_b;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    check("done_pulse", 32'(bus_a.done), 32'd0);
  endtask

  int v;
  int done_seen;

  initial begin
    resetn = 1'b0;
    drive(1'b0, 0);
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_bcd", 32'(bus_a.bcd), 32'd0);
    check("rst_ovf", 32'(bus_a.overflow), 32'd0);
`ifdef BCD_SEG7_EN
    check("rst_seg", 32'(bus_a.seg), 32'(ref_seg(12'h000)));
`endif
    resetn = 1'b1;
    @(negedge clock);

    convert(255, 1'b0);
    check("t1_bcd", 32'(bus_a.bcd), 32'h255);
    idle_cycle();

    convert(0, 1'b0);
    convert(99, 1'b0);
    check("t2_bcd", 32'(bus_a.bcd), 32'h099);
    idle_cycle();

    convert(128, 1'b1);
    idle_cycle();
    check("t3_hold", 32'(bus_a.bcd), 32'h128);

    convert(200, 1'b0);
    check("t4_sat", 32'(bus_b.bcd), 32'h99);
    idle_cycle();
    convert(42, 1'b0);
    check("t4_exact", 32'(bus_b.bcd), 32'h42);
    idle_cycle();

    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 255));
      convert(v, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) begin
        idle_cycle();
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end
    idle_cycle();

    // Asynchronous abort in the middle of a conversion
    drive(1'b1, 173);
    @(negedge clock);
    drive(1'b0, 173);
    repeat (3) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("abort_busy", 32'(bus_a.busy), 32'd0);
    check("abort_done", 32'(bus_a.done), 32'd0);
    check("abort_bcd", 32'(bus_a.bcd), 32'd0);
    check("abort_ovf_b", 32'(bus_b.overflow), 32'd0);
    check("abort_bcd_b", 32'(bus_b.bcd), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    prev_a = '0;
    prev_b = '0;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (bus_a.done || bus_a.busy) done_seen++;
    end
    check("abort_quiet", 32'(done_seen), 32'd0);

    convert(37, 1'b0);
    idle_cycle();
`ifdef BCD_SEG7_EN
    check("t6_seg", 32'(bus_a.seg), {11'd0, 7'b1000000, 7'b0110000, 7'b1111000});
`endif
    check("t6_bcd", 32'(bus_a.bcd), 32'h037);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
